bus_arbiter_ctrl: RTL and testbench
===================================

// Module: bus_arbiter_ctrl
// PURPOSE
// Central arbiter for the serial bus interconnect. Shares the bus between NO_MASTERS masters on request.
// Drives the interconnect mux selects: addr_select, MOSI_data_select, valid_select, last_select, MISO_data_select and ready_select.
// Round-robin fairness, with THRESH-cycle time-slice preemption (split) when other masters are waiting.
// PARAMETERS
// NO_MASTERS  2                         number of masters
// NO_SLAVES   3                         number of slaves; slave id 0 = "no slave", valid ids 1..NO_SLAVES
// THRESH      1000                      max ACTIVE cycles before a waiting master forces a split
// S_ID_WIDTH  $clog2(NO_SLAVES+1)       slave id width (2)
// M_ID_WIDTH  $clog2(NO_MASTERS)        master id width (1)
// PORTS
// clk               in   1                         bus clock, single clock domain
// rst               in   1                         synchronous, active-high reset
// m_req             in   NO_MASTERS                master i requests the bus (level, held until granted/finished)
// m_slave_id        in   NO_MASTERS*S_ID_WIDTH     target slave of master i, sampled at grant
// m_done            in   NO_MASTERS                1-cycle pulse: master i releases the bus
// m_grant           out  NO_MASTERS                one-hot grant, at most one bit high
// m_split           out  NO_MASTERS                preemption request to the granted master, level
// addr_select       out  M_ID_WIDTH                master driving control line
// MOSI_data_select  out  M_ID_WIDTH                master driving wD
// valid_select      out  M_ID_WIDTH                master driving valid
// last_select       out  M_ID_WIDTH                master driving last
// MISO_data_select  out  S_ID_WIDTH                slave driving rD (0 = none)
// ready_select      out  S_ID_WIDTH                slave driving ready (0 = none)
// bus_busy          out  1                         high in ACTIVE/SPLIT
// BEHAVIOUR
// - Reset:
//   - All outputs are registered and reset to 0; state=IDLE, rr_ptr=0, timer=0.
//   - rst wins over every other input on the same edge. Mid-transfer reset drops grant and selects at the next edge.
// - FSM states: IDLE, ACTIVE, SPLIT, RELEASE.
// - IDLE:
//   - A master i is eligible when m_req[i]=1 and m_slave_id[i] is in 1..NO_SLAVES. Requests with id 0 or >NO_SLAVES are ignored.
//   - The winner is the first eligible master at or after rr_ptr, wrapping.
//   - Next edge: state=ACTIVE, m_grant one-hot to the winner. All four master selects = winner.
//   - MISO_data_select and ready_select = latched m_slave_id. timer=0. Grant latency: 1 cycle from req.
// - ACTIVE:
//   - timer increments, saturating at THRESH.
//   - m_done[g]=1, or m_req[g]=0: go to RELEASE.
//   - timer==THRESH and another master eligible: go to SPLIT, m_split[g]=1.
//   - timer==THRESH with nobody waiting: stay ACTIVE; split as soon as a competitor appears.
//   - m_done/m_req from non-granted masters have no effect on state (queued requests only).
// - SPLIT:
//   - Hold m_split[g], grant and selects until m_done[g] (or m_req[g]=0), then go to RELEASE.
// - Done vs. split:
//   - m_done[g] in the same cycle timer reaches THRESH: done wins; no split is raised.
// - RELEASE (1 cycle):
//   - m_grant=0, m_split=0, slave selects=0; master selects hold their last value (bus parked).
//   - rr_ptr = g+1 mod NO_MASTERS. Then IDLE.
//   - Minimum bus turnaround between owners: RELEASE + IDLE = 2 cycles.
// - Width rules: timer is $clog2(THRESH+1) bits. rr_ptr is M_ID_WIDTH bits, wrapping at NO_MASTERS (not a power of 2 in general).
// - Invariants:
//   - $onehot0(m_grant).
//   - m_split only while the matching m_grant is high.
//   - Select outputs stable for the whole grant.
// STRUCTURE
// - bus_pkg: arb_state_t enum {IDLE,ACTIVE,SPLIT,RELEASE}; SLAVE_NONE='0 constant.
// - Sub-module rr_picker: combinational; inputs eligible vector and rr_ptr; outputs winner id and valid. Instantiated once.
// - Everything else (FSM, timer, select registers) lives in bus_arbiter_ctrl.
// TESTING
// - Reset: rst=1 for 2 cycles with m_req=2'b11 -> all outputs 0, state IDLE. Drop rst -> m_grant=2'b01 one cycle later.
// - Simultaneous: m_req=11, ids 2/3 -> M0 granted, selects M0, slave selects=2. M0 m_done -> RELEASE, then M1 granted, slave selects=3.
// - Invalid id: M0 req with id 0 -> never granted; M1 req id 1 -> granted while M0 stays pending.
// - Timeout, THRESH=8:
//   - M0 ACTIVE, M1 requests at cycle 3: m_split[0] at cycle 8; grant held until M0 m_done; M1 granted 2 cycles later.
//   - No competitor: no split after 20 cycles.
// - Done vs. split: m_done[0] exactly on the timer==THRESH cycle -> no m_split pulse; normal RELEASE.
// - Mid-transfer reset: rst during ACTIVE -> m_grant/selects 0 next edge; fairness restarts from M0.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the bus arbiter
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        SPLIT   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int SLAVE_NONE = 0;

endpackage

// File: rtl/bus_arbiter_ctrl_rr_picker.sv
// rtl/bus_arbiter_ctrl_rr_picker.sv - combinational round-robin winner selection
module rr_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] rr_ptr,
    output logic [W-1:0] winner,
    output logic         valid
);

    // Scan from rr_ptr upward with wrap; first hit wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && eligible[(int'(rr_ptr) + k) % N]) begin
                valid  = 1'b1;
                winner = W'((int'(rr_ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_ctrl.sv
// rtl/bus_arbiter_ctrl.sv - round-robin bus arbiter with time-slice split
module bus_arbiter_ctrl
    import bus_pkg::*;
#(
    parameter int NO_MASTERS = 2,
    parameter int NO_SLAVES  = 3,
    parameter int THRESH     = 1000,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int M_ID_WIDTH = (NO_MASTERS > 1) ? $clog2(NO_MASTERS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NO_MASTERS-1:0]            m_req,
    input  logic [NO_MASTERS*S_ID_WIDTH-1:0] m_slave_id,
    input  logic [NO_MASTERS-1:0]            m_done,
    output logic [NO_MASTERS-1:0]            m_grant,
    output logic [NO_MASTERS-1:0]            m_split,
    output logic [M_ID_WIDTH-1:0]            addr_select,
    output logic [M_ID_WIDTH-1:0]            MOSI_data_select,
    output logic [M_ID_WIDTH-1:0]            valid_select,
    output logic [M_ID_WIDTH-1:0]            last_select,
    output logic [S_ID_WIDTH-1:0]            MISO_data_select,
    output logic [S_ID_WIDTH-1:0]            ready_select,
    output logic                             bus_busy
);

    localparam int TW = $clog2(THRESH + 1);

    arb_state_t                state, state_nxt;
    logic [NO_MASTERS-1:0]     grant_nxt, split_nxt, eligible;
    logic [M_ID_WIDTH-1:0]     msel, msel_nxt, rr_ptr, rr_ptr_nxt, winner;
    logic [S_ID_WIDTH-1:0]     ssel, ssel_nxt, win_id;
    logic [TW-1:0]             timer, timer_nxt, timer_inc;
    logic                      busy_nxt, win_valid, owner_leaving, others_waiting;

    always_comb begin
        eligible = '0;
        win_id   = '0;
        for (int i = 0; i < NO_MASTERS; i++) begin
            eligible[i] = m_req[i]
                && (m_slave_id[i*S_ID_WIDTH +: S_ID_WIDTH] != S_ID_WIDTH'(SLAVE_NONE))
                && (m_slave_id[i*S_ID_WIDTH +: S_ID_WIDTH] <= S_ID_WIDTH'(NO_SLAVES));
            if (M_ID_WIDTH'(i) == winner)
                win_id = m_slave_id[i*S_ID_WIDTH +: S_ID_WIDTH];
        end
    end

    rr_picker #(.N(NO_MASTERS), .W(M_ID_WIDTH)) u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .winner   (winner),
        .valid    (win_valid)
    );

    assign timer_inc      = (timer == TW'(THRESH)) ? timer : timer + 1'b1;
    assign owner_leaving  = m_done[msel] || !m_req[msel];
    assign others_waiting = |(eligible & ~m_grant);

    always_comb begin
        state_nxt  = state;
        grant_nxt  = m_grant;
        split_nxt  = m_split;
        msel_nxt   = msel;
        ssel_nxt   = ssel;
        rr_ptr_nxt = rr_ptr;
        timer_nxt  = timer;
        busy_nxt   = bus_busy;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nxt         = ACTIVE;
                    grant_nxt         = '0;
                    grant_nxt[winner] = 1'b1;
                    msel_nxt          = winner;
                    ssel_nxt          = win_id;
                    timer_nxt         = '0;
                    busy_nxt          = 1'b1;
                end
            end
            ACTIVE: begin
                timer_nxt = timer_inc;
                // Owner release beats a split decided on the same cycle.
                if (owner_leaving) begin
                    state_nxt = RELEASE;
                end else if (timer_inc == TW'(THRESH) && others_waiting) begin
                    state_nxt = SPLIT;
                    split_nxt = m_grant;
                end
            end
            SPLIT: begin
                if (owner_leaving)
                    state_nxt = RELEASE;
            end
            RELEASE: begin
                state_nxt  = IDLE;
                rr_ptr_nxt = (msel == M_ID_WIDTH'(NO_MASTERS - 1)) ? '0 : msel + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        // Master selects stay parked on the last owner through release.
        if (state_nxt == RELEASE) begin
            grant_nxt = '0;
            split_nxt = '0;
            ssel_nxt  = S_ID_WIDTH'(SLAVE_NONE);
            busy_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            m_grant  <= '0;
            m_split  <= '0;
            msel     <= '0;
            ssel     <= '0;
            rr_ptr   <= '0;
            timer    <= '0;
            bus_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            m_grant  <= grant_nxt;
            m_split  <= split_nxt;
            msel     <= msel_nxt;
            ssel     <= ssel_nxt;
            rr_ptr   <= rr_ptr_nxt;
            timer    <= timer_nxt;
            bus_busy <= busy_nxt;
        end
    end

    assign addr_select      = msel;
    assign MOSI_data_select = msel;
    assign valid_select     = msel;
    assign last_select      = msel;
    assign MISO_data_select = ssel;
    assign ready_select     = ssel;

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// tb/tb_bus_arbiter_ctrl.sv - directed self-checking bench for bus_arbiter_ctrl
module tb_bus_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] m_req;
    logic [3:0] m_slave_id;
    logic [1:0] m_done;
    logic [1:0] m_grant, m_split;
    logic       addr_select, MOSI_data_select, valid_select, last_select;
    logic [1:0] MISO_data_select, ready_select;
    logic       bus_busy;

    int tests  = 0;
    int failed = 0;

    bus_arbiter_ctrl #(.NO_MASTERS(2), .NO_SLAVES(3), .THRESH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .m_req            (m_req),
        .m_slave_id       (m_slave_id),
        .m_done           (m_done),
        .m_grant          (m_grant),
        .m_split          (m_split),
        .addr_select      (addr_select),
        .MOSI_data_select (MOSI_data_select),
        .valid_select     (valid_select),
        .last_select      (last_select),
        .MISO_data_select (MISO_data_select),
        .ready_select     (ready_select),
        .bus_busy         (bus_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; m_req = 2'b00; m_done = 2'b00; m_slave_id = 4'b0000;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_req = 2'b11; m_done = 2'b00; m_slave_id = {2'd3, 2'd2};
        tick(); tick();
        tests++;
        if ({m_grant, m_split, addr_select, MOSI_data_select, valid_select, last_select,
             MISO_data_select, ready_select, bus_busy} !== 15'd0) begin
            failed++;
            $display("FAIL reset_outputs: grant=%b split=%b asel=%b miso=%0d rdy=%0d busy=%b required all 0",
                     m_grant, m_split, addr_select, MISO_data_select, ready_select, bus_busy);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (m_grant !== 2'b01 || bus_busy !== 1'b1) begin
            failed++;
            $display("FAIL reset_first_grant: grant=%b busy=%b required 01/1", m_grant, bus_busy);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        m_slave_id = {2'd3, 2'd2}; m_req = 2'b11;
        tick();
        tests++;
        if (m_grant !== 2'b01 || addr_select !== 1'b0 || MOSI_data_select !== 1'b0 ||
            MISO_data_select !== 2'd2 || ready_select !== 2'd2) begin
            failed++;
            $display("FAIL simul_m0_grant: grant=%b asel=%b mosi=%b miso=%0d rdy=%0d required 01/0/0/2/2",
                     m_grant, addr_select, MOSI_data_select, MISO_data_select, ready_select);
        end
        m_done = 2'b01; m_req = 2'b10;
        tick();
        m_done = 2'b00;
        tests++;
        if (m_grant !== 2'b00 || MISO_data_select !== 2'd0 || addr_select !== 1'b0 || bus_busy !== 1'b0) begin
            failed++;
            $display("FAIL simul_release: grant=%b miso=%0d asel=%b busy=%b required 00/0/0/0",
                     m_grant, MISO_data_select, addr_select, bus_busy);
        end
        tick();
        tests++;
        if (m_grant !== 2'b00) begin
            failed++;
            $display("FAIL simul_turnaround: grant=%b required 00", m_grant);
        end
        tick();
        tests++;
        if (m_grant !== 2'b10 || addr_select !== 1'b1 || valid_select !== 1'b1 || last_select !== 1'b1 ||
            MISO_data_select !== 2'd3 || ready_select !== 2'd3) begin
            failed++;
            $display("FAIL simul_m1_grant: grant=%b asel=%b vsel=%b lsel=%b miso=%0d rdy=%0d required 10/1/1/1/3/3",
                     m_grant, addr_select, valid_select, last_select, MISO_data_select, ready_select);
        end
    endtask

    task automatic test_invalid_id();
        apply_reset();
        m_slave_id = {2'd1, 2'd0}; m_req = 2'b01;
        tick(); tick(); tick();
        tests++;
        if (m_grant !== 2'b00 || bus_busy !== 1'b0) begin
            failed++;
            $display("FAIL invalid_id_ignored: grant=%b busy=%b required 00/0", m_grant, bus_busy);
        end
        m_req = 2'b11;
        tick();
        tests++;
        if (m_grant !== 2'b10 || MISO_data_select !== 2'd1) begin
            failed++;
            $display("FAIL invalid_id_m1: grant=%b miso=%0d required 10/1", m_grant, MISO_data_select);
        end
        tick(); tick();
        tests++;
        if (m_grant !== 2'b10) begin
            failed++;
            $display("FAIL invalid_id_hold: grant=%b required 10", m_grant);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        m_slave_id = {2'd1, 2'd2}; m_req = 2'b01;
        tick();
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 3) m_req = 2'b11;
            tests++;
            if (m_split !== 2'b00) begin
                failed++;
                $display("FAIL timeout_early_split c=%0d: split=%b required 00", c, m_split);
            end
        end
        tick();
        tests++;
        if (m_split !== 2'b01 || m_grant !== 2'b01) begin
            failed++;
            $display("FAIL timeout_split_c8: split=%b grant=%b required 01/01", m_split, m_grant);
        end
        tick(); tick(); tick();
        tests++;
        if (m_split !== 2'b01 || m_grant !== 2'b01 || addr_select !== 1'b0 || MISO_data_select !== 2'd2) begin
            failed++;
            $display("FAIL timeout_split_hold: split=%b grant=%b asel=%b miso=%0d required 01/01/0/2",
                     m_split, m_grant, addr_select, MISO_data_select);
        end
        m_done = 2'b01; m_req = 2'b10;
        tick();
        m_done = 2'b00;
        tests++;
        if (m_split !== 2'b00 || m_grant !== 2'b00) begin
            failed++;
            $display("FAIL timeout_release: split=%b grant=%b required 00/00", m_split, m_grant);
        end
        tick(); tick();
        tests++;
        if (m_grant !== 2'b10 || MISO_data_select !== 2'd1) begin
            failed++;
            $display("FAIL timeout_m1_grant: grant=%b miso=%0d required 10/1", m_grant, MISO_data_select);
        end
    endtask

    task automatic test_no_competitor();
        apply_reset();
        m_slave_id = {2'd1, 2'd2}; m_req = 2'b01;
        tick();
        for (int c = 1; c <= 20; c++) tick();
        tests++;
        if (m_split !== 2'b00 || m_grant !== 2'b01) begin
            failed++;
            $display("FAIL no_competitor: split=%b grant=%b required 00/01", m_split, m_grant);
        end
        m_req = 2'b11;
        tick();
        tests++;
        if (m_split !== 2'b01 || m_grant !== 2'b01) begin
            failed++;
            $display("FAIL late_competitor_split: split=%b grant=%b required 01/01", m_split, m_grant);
        end
    endtask

    task automatic test_done_vs_split();
        apply_reset();
        m_slave_id = {2'd3, 2'd2}; m_req = 2'b11;
        tick();
        for (int c = 1; c <= 7; c++) tick();
        m_done = 2'b01;
        tick();
        m_done = 2'b00;
        tests++;
        if (m_split !== 2'b00 || m_grant !== 2'b00) begin
            failed++;
            $display("FAIL done_wins: split=%b grant=%b required 00/00", m_split, m_grant);
        end
        tick(); tick();
        tests++;
        if (m_grant !== 2'b10 || MISO_data_select !== 2'd3 || m_split !== 2'b00) begin
            failed++;
            $display("FAIL done_rr_next: grant=%b miso=%0d split=%b required 10/3/00",
                     m_grant, MISO_data_select, m_split);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        m_slave_id = {2'd3, 2'd2}; m_req = 2'b11;
        tick();
        m_done = 2'b01;
        tick();
        m_done = 2'b00;
        tick(); tick();
        tests++;
        if (m_grant !== 2'b10 || addr_select !== 1'b1) begin
            failed++;
            $display("FAIL midrst_setup: grant=%b asel=%b required 10/1", m_grant, addr_select);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (m_grant !== 2'b00 || addr_select !== 1'b0 || MISO_data_select !== 2'd0 || bus_busy !== 1'b0) begin
            failed++;
            $display("FAIL midrst_drop: grant=%b asel=%b miso=%0d busy=%b required 00/0/0/0",
                     m_grant, addr_select, MISO_data_select, bus_busy);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (m_grant !== 2'b01 || MISO_data_select !== 2'd2) begin
            failed++;
            $display("FAIL midrst_fairness: grant=%b miso=%0d required 01/2", m_grant, MISO_data_select);
        end
    endtask

    initial begin
        rst = 1'b1; m_req = 2'b00; m_done = 2'b00; m_slave_id = 4'b0000;
        test_reset();
        test_simultaneous();
        test_invalid_id();
        test_timeout();
        test_no_competitor();
        test_done_vs_split();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
